// File: rtl/lsm.sv
// lsm: load/store stage downstream of execute.
//   Non-memory instructions pass straight to the register-file write port
//   with one cycle of latency. Loads and stores run one pipelined
//   Wishbone-style bus transaction (REQUEST -> optional WAIT_ACK -> IDLE).
//   Loads write back on the cycle after the ack. Stores do not write back.
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   input_*/result_*/ls_* instruction interface from execute
//   mem_*                 data bus (cyc/stb/we/addr/sel/dat, stall/ack/dat_i)
//   reg_*                 registered register-file write (strobe, index, data)
//   misaligned_o          one-cycle pulse for a rejected misaligned access
module lsm (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] result_i,
    input  logic        result_write_i,
    input  logic [4:0]  result_addr_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [1:0]  ls_size_i,
    input  logic        ls_unsigned_i,
    input  logic [31:0] ls_write_data_i,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_dat_o,
    input  logic        mem_stall_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dat_i,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o,
    output logic        misaligned_o
);
    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdat_q, wdat_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic        rwrite_q, rwrite_d;
    logic [4:0]  raddr_q, raddr_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [31:0] reg_data_q, reg_data_d;
    logic        mis_q, mis_d;

    logic        accept, misalign, done;
    logic [3:0]  sel_in;
    logic [31:0] dat_in, shifted, load_val;

    // Bus control decoded straight from state so a reset drops cyc/stb at once.
    assign input_ready_o = (state_q == IDLE);
    assign mem_cyc_o     = (state_q != IDLE);
    assign mem_stb_o     = (state_q == REQUEST);
    assign mem_we_o      = we_q & (state_q != IDLE);
    assign mem_addr_o    = addr_q;
    assign mem_sel_o     = sel_q;
    assign mem_dat_o     = wdat_q;
    assign reg_write_o   = reg_write_q;
    assign reg_addr_o    = reg_addr_q;
    assign reg_data_o    = reg_data_q;
    assign misaligned_o  = mis_q;

    assign accept   = input_ready_o & input_valid_i;
    assign misalign = ((ls_size_i == 2'd1) && result_i[0]) ||
                      (ls_size_i[1] && (result_i[1:0] != 2'b00));

    // Ack only counts while a cycle is open, and in REQUEST only if not stalled.
    assign done = ((state_q == REQUEST) && !mem_stall_i && mem_ack_i) ||
                  ((state_q == WAIT_ACK) && mem_ack_i);

    always_comb begin
        sel_in = 4'b1111;
        dat_in = ls_write_data_i;
        case (ls_size_i)
            2'd0: begin
                sel_in = 4'b0001 << result_i[1:0];
                dat_in = {4{ls_write_data_i[7:0]}};
            end
            2'd1: begin
                sel_in = 4'b0011 << result_i[1:0];
                dat_in = {2{ls_write_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Align the addressed bytes to bit 0, then truncate and extend.
    assign shifted = mem_dat_i >> {off_q, 3'b000};
    always_comb begin
        load_val = shifted;
        case (size_q)
            2'd0: load_val = uns_q ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_val = uns_q ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdat_d      = wdat_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        rwrite_d    = rwrite_q;
        raddr_d     = raddr_q;
        reg_write_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        mis_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !ls_enable_i) begin
                    if (result_write_i && (result_addr_i != 5'd0)) begin
                        reg_write_d = 1'b1;
                        reg_addr_d  = result_addr_i;
                        reg_data_d  = result_i;
                    end
                end else if (accept && misalign) begin
                    mis_d = 1'b1;
                end else if (accept) begin
                    state_d  = REQUEST;
                    addr_d   = {result_i[31:2], 2'b00};
                    off_d    = result_i[1:0];
                    sel_d    = sel_in;
                    wdat_d   = dat_in;
                    size_d   = ls_size_i;
                    uns_d    = ls_unsigned_i;
                    we_d     = ls_write_i;
                    rwrite_d = result_write_i;
                    raddr_d  = result_addr_i;
                end
            end
            REQUEST: begin
                if (!mem_stall_i) state_d = mem_ack_i ? IDLE : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done && !we_q && rwrite_q && (raddr_q != 5'd0)) begin
            reg_write_d = 1'b1;
            reg_addr_d  = raddr_q;
            reg_data_d  = load_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            sel_q       <= '0;
            wdat_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            rwrite_q    <= 1'b0;
            raddr_q     <= '0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdat_q      <= wdat_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            rwrite_q    <= rwrite_d;
            raddr_q     <= raddr_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            mis_q       <= mis_d;
        end
    end
endmodule

// File: tb/tb_lsm.sv
// Bench for lsm: directed instructions; expected register-file writes are
// queued at issue time and a separate monitor pops/compares each reg_write.
module tb_lsm;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        input_ready_o, input_valid_i;
    logic [31:0] result_i;
    logic        result_write_i;
    logic [4:0]  result_addr_i;
    logic        ls_enable_i, ls_write_i, ls_unsigned_i;
    logic [1:0]  ls_size_i;
    logic [31:0] ls_write_data_i;
    logic        mem_cyc_o, mem_stb_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_dat_o;
    logic [3:0]  mem_sel_o;
    logic        mem_stall_i, mem_ack_i;
    logic [31:0] mem_dat_i;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o;
    logic        misaligned_o;

    lsm dut (
        .clk_i(clk_i), .rst_i(rst_i), .input_ready_o(input_ready_o),
        .input_valid_i(input_valid_i), .result_i(result_i),
        .result_write_i(result_write_i), .result_addr_i(result_addr_i),
        .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i),
        .ls_size_i(ls_size_i), .ls_unsigned_i(ls_unsigned_i),
        .ls_write_data_i(ls_write_data_i), .mem_cyc_o(mem_cyc_o),
        .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_dat_o(mem_dat_o),
        .mem_stall_i(mem_stall_i), .mem_ack_i(mem_ack_i),
        .mem_dat_i(mem_dat_i), .reg_write_o(reg_write_o),
        .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
        .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Presents one instruction for a single accepting edge.
    task automatic issue(input logic ls, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] res,
                         input logic [31:0] wd, input logic rw, input logic [4:0] ra);
        ls_enable_i     = ls;
        ls_write_i      = we;
        ls_size_i       = sz;
        ls_unsigned_i   = uns;
        result_i        = res;
        ls_write_data_i = wd;
        result_write_i  = rw;
        result_addr_i   = ra;
        input_valid_i   = 1'b1;
        @(posedge clk_i);
        #1;
        input_valid_i   = 1'b0;
    endtask

    // Monitor: every register-file write must match the head of the queue.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b1 && reg_write_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_reg_write", {27'b0, reg_addr_o}, 32'h0000_0000);
                end else begin
                    w = exp_q.pop_front();
                    chk("wb_addr", {27'b0, reg_addr_o}, {27'b0, w.a});
                    chk("wb_data", reg_data_o, w.d);
                end
            end
        end
    end

    // One load with an ack on the first REQUEST cycle.
    task automatic load_fast(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                             input logic [31:0] rd, input logic [4:0] ra,
                             input logic [31:0] exp_addr, input logic [3:0] exp_sel);
        issue(1'b1, 1'b0, sz, uns, a, 32'h0, 1'b1, ra);
        mem_ack_i = 1'b1;
        mem_dat_i = rd;
        @(negedge clk_i);
        chk("ld_cyc_stb", {30'b0, mem_cyc_o, mem_stb_o}, 32'h3);
        chk("ld_addr", mem_addr_o, exp_addr);
        chk("ld_sel", {28'b0, mem_sel_o}, {28'b0, exp_sel});
        chk("ld_ready_busy", {31'b0, input_ready_o}, 32'h0);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("ld_done_cyc_ready", {30'b0, mem_cyc_o, input_ready_o}, 32'h1);
    endtask

    initial begin
        rst_i = 1'b0; input_valid_i = 1'b0; result_i = '0; result_write_i = 1'b0;
        result_addr_i = '0; ls_enable_i = 1'b0; ls_write_i = 1'b0; ls_size_i = '0;
        ls_unsigned_i = 1'b0; ls_write_data_i = '0; mem_stall_i = 1'b0;
        mem_ack_i = 1'b0; mem_dat_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ctrl", {26'b0, mem_cyc_o, mem_stb_o, mem_we_o, reg_write_o, misaligned_o, input_ready_o}, 32'h1);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_sel_raddr", {23'b0, mem_sel_o, reg_addr_o}, 32'h0);
        chk("rst_dat", mem_dat_o, 32'h0);
        chk("rst_rdata", reg_data_o, 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Pass-through, back to back: a write must appear every cycle.
        for (int i = 0; i < 4; i++) begin
            push(5'd5 + 5'(i), 32'h1234_5678 + i);
            issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678 + i, 32'h0, 1'b1, 5'd5 + 5'(i));
            @(negedge clk_i);
            chk("pt_throughput", {30'b0, reg_write_o, input_ready_o}, 32'h3);
        end
        // No-write ALU op and x0 ALU op: nothing queued.
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'hAAAA_0000, 32'h0, 1'b0, 5'd6);
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'hBBBB_0000, 32'h0, 1'b1, 5'd0);
        @(negedge clk_i);
        chk("x0_alu_nowrite", {31'b0, reg_write_o}, 32'h0);

        // Signed and unsigned byte load from the top lane.
        push(5'd7, 32'hFFFF_FF80);
        load_fast(2'd0, 1'b0, 32'h0000_1003, 32'h80AA_BBCC, 5'd7, 32'h0000_1000, 4'b1000);
        push(5'd8, 32'h0000_0080);
        load_fast(2'd0, 1'b1, 32'h0000_1003, 32'h80AA_BBCC, 5'd8, 32'h0000_1000, 4'b1000);
        // Signed halfword from the upper half.
        push(5'd9, 32'hFFFF_8001);
        load_fast(2'd1, 1'b0, 32'h0000_0012, 32'h8001_0000, 5'd9, 32'h0000_0010, 4'b1100);
        // Word load into x0: bus runs, no writeback.
        load_fast(2'd2, 1'b0, 32'h0000_0040, 32'h1111_2222, 5'd0, 32'h0000_0040, 4'b1111);

        // Halfword store with 3 stall cycles, then ack 2 cycles after stb drops.
        @(posedge clk_i);
        #1;
        issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 1'b1, 5'd3);
        mem_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("st_stall_ctrl", {28'b0, mem_cyc_o, mem_stb_o, mem_we_o, input_ready_o}, 32'hE);
            chk("st_sel", {28'b0, mem_sel_o}, 32'hC);
            chk("st_dat", mem_dat_o, 32'hBEEF_BEEF);
            chk("st_addr", mem_addr_o, 32'h0000_0020);
            @(posedge clk_i);
            #1;
        end
        mem_stall_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("st_wait_ctrl", {29'b0, mem_cyc_o, mem_stb_o, input_ready_o}, 32'h4);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        chk("st_wait2_ctrl", {29'b0, mem_cyc_o, mem_stb_o, input_ready_o}, 32'h4);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("st_done", {29'b0, mem_cyc_o, reg_write_o, input_ready_o}, 32'h1);

        // Misaligned word load.
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 1'b1, 5'd10);
        @(negedge clk_i);
        chk("mis_pulse", {27'b0, mem_cyc_o, mem_stb_o, reg_write_o, misaligned_o, input_ready_o}, 32'h3);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("mis_one_cycle", {30'b0, misaligned_o, mem_cyc_o}, 32'h0);

        // Reset in WAIT_ACK, then a late ack.
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 5'd4);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("rma_wait", {30'b0, mem_cyc_o, mem_stb_o}, 32'h2);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("rma_reset", {30'b0, mem_cyc_o, input_ready_o}, 32'h1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b1;
        mem_dat_i = 32'hCAFE_F00D;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("rma_late_ack", {29'b0, mem_cyc_o, reg_write_o, input_ready_o}, 32'h1);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
